stopwatch_ctrl: RTL and testbench

- Downstream consumer of the clock divider.
- Samples the divider's divided clock `div_clk`, edge-detects it in the `clk` domain, and runs an MM:SS BCD stopwatch.
- Start/stop and lap/reset are controlled by single-cycle, pre-debounced button pulses.
- Drives `stop` back to the divider so the divided clock is frozen whenever the stopwatch is not running.

---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/stopwatch_ctrl_bcd_digit_counter.sv | 24 ++
 rtl/stopwatch_ctrl.sv | 133 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types, digit limits and the BCD step helper for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_ONES_MAX = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t MIN_ONES_MAX = 4'd9;
    localparam bcd_t MIN_TENS_MAX = 4'd5;

    // Value a digit counter will hold after the coming edge.
    function automatic bcd_t bcd_next(input bcd_t digit, input bcd_t max,
                                      input logic en, input logic clr);
        if (clr)
            return '0;
        else if (en)
            return (digit == max) ? '0 : bcd_t'(digit + 4'd1);
        else
            return digit;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit_counter.sv
// Single BCD digit that wraps at MAX; carry flags the wrap so digits can be chained.
import stopwatch_pkg::*;

module bcd_digit_counter #(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output bcd_t digit,
    output logic carry
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            digit <= '0;
        else
            digit <= bcd_next(digit, MAX, en, clr);
    end

    assign carry = en & (digit == MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS BCD stopwatch driven by the divider's div_clk; freezes the divider via stop.
// Define STOPWATCH_SAT_EN to saturate at 59:59 with a sticky overflow instead of wrapping.
import stopwatch_pkg::*;

module stopwatch_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       div_clk,
    input  logic       btn_ss,
    input  logic       btn_lr,
    output logic       stop,
    output logic       running,
    output logic       lap_hold,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       overflow
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   tick;

    sw_state_t state, next_state;

    logic count_en, clr, at_max, en0;
    logic cy0, cy1, cy2, cy3;
    bcd_t cnt_so, cnt_st, cnt_mo, cnt_mt;
    bcd_t nxt_so, nxt_st, nxt_mo, nxt_mt;
    bcd_t disp_so, disp_st, disp_mo, disp_mt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], div_clk};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    assign tick = sync[SYNC_STAGES-1] & ~hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // btn_ss is checked first in every state so it wins over a simultaneous btn_lr.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (btn_ss) next_state = RUN;
            RUN:     if (btn_ss) next_state = PAUSE;
                     else if (btn_lr) next_state = LAP;
            LAP:     if (btn_ss) next_state = PAUSE;
                     else if (btn_lr) next_state = RUN;
            PAUSE:   if (btn_ss) next_state = RUN;
                     else if (btn_lr) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign count_en = tick & ((state == RUN) || (state == LAP));
    assign clr      = (state == PAUSE) & ~btn_ss & btn_lr;
    assign at_max   = (cnt_so == SEC_ONES_MAX) && (cnt_st == SEC_TENS_MAX) &&
                      (cnt_mo == MIN_ONES_MAX) && (cnt_mt == MIN_TENS_MAX);

`ifdef STOPWATCH_SAT_EN
    assign en0 = count_en & ~at_max;
`else
    assign en0 = count_en;
`endif

    bcd_digit_counter #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk(clk), .reset_n(reset_n), .clr(clr), .en(en0), .digit(cnt_so), .carry(cy0));
    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .reset_n(reset_n), .clr(clr), .en(cy0), .digit(cnt_st), .carry(cy1));
    bcd_digit_counter #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clk(clk), .reset_n(reset_n), .clr(clr), .en(cy1), .digit(cnt_mo), .carry(cy2));
    bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .reset_n(reset_n), .clr(clr), .en(cy2), .digit(cnt_mt), .carry(cy3));

    assign nxt_so = bcd_next(cnt_so, SEC_ONES_MAX, en0, clr);
    assign nxt_st = bcd_next(cnt_st, SEC_TENS_MAX, cy0, clr);
    assign nxt_mo = bcd_next(cnt_mo, MIN_ONES_MAX, cy1, clr);
    assign nxt_mt = bcd_next(cnt_mt, MIN_TENS_MAX, cy2, clr);

    // Display register tracks the counter's next value so it updates on the same edge,
    // and doubles as the lap latch: captured on RUN->LAP, held while in LAP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {disp_mt, disp_mo, disp_st, disp_so} <= '0;
        end else if (next_state == LAP) begin
            if (state != LAP)
                {disp_mt, disp_mo, disp_st, disp_so} <= {cnt_mt, cnt_mo, cnt_st, cnt_so};
        end else begin
            {disp_mt, disp_mo, disp_st, disp_so} <= {nxt_mt, nxt_mo, nxt_st, nxt_so};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stop     <= 1'b1;
            running  <= 1'b0;
            lap_hold <= 1'b0;
            overflow <= 1'b0;
        end else begin
            stop     <= (next_state == IDLE) || (next_state == PAUSE);
            running  <= (next_state == RUN) || (next_state == LAP);
            lap_hold <= (next_state == LAP);
`ifdef STOPWATCH_SAT_EN
            if (clr)
                overflow <= 1'b0;
            else if (count_en & at_max)
                overflow <= 1'b1;
`else
            overflow <= cy3;
`endif
        end
    end

    assign sec_ones = disp_so;
    assign sec_tens = disp_st;
    assign min_ones = disp_mo;
    assign min_tens = disp_mt;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl; follows STOPWATCH_SAT_EN if defined.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       div_clk = 1'b0;
    logic       btn_ss = 1'b0;
    logic       btn_lr = 1'b0;
    logic       stop, running, lap_hold, overflow;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .div_clk(div_clk),
        .btn_ss(btn_ss), .btn_lr(btn_lr),
        .stop(stop), .running(running), .lap_hold(lap_hold),
        .sec_ones(sec_ones), .sec_tens(sec_tens),
        .min_ones(min_ones), .min_tens(min_tens),
        .overflow(overflow)
    );

    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_display(input string tag, input logic [15:0] expected);
        check_output(tag, {min_tens, min_ones, sec_tens, sec_ones}, expected);
    endtask

    // Flags packed as {stop, running, lap_hold, overflow} in the low nibble.
    task automatic check_flags(input string tag, input logic [3:0] expected);
        check_output(tag, {12'd0, stop, running, lap_hold, overflow}, {12'd0, expected});
    endtask

    task automatic apply_stimulus(input logic ss, input logic lr);
        btn_ss = ss;
        btn_lr = lr;
        @(negedge clk);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
    endtask

    // One-cycle div_clk pulse; returns just after the edge that counts it.
    task automatic tick_once();
        div_clk = 1'b1;
        @(negedge clk);
        div_clk = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Tick whose counting edge coincides with a button pulse.
    task automatic tick_with_button(input logic ss, input logic lr);
        div_clk = 1'b1;
        @(negedge clk);
        div_clk = 1'b0;
        @(negedge clk);
        apply_stimulus(ss, lr);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_display("reset_display", 16'h0000);
        check_flags("reset_flags", 4'b1000);
        reset_n = 1'b1;
        @(negedge clk);

        apply_stimulus(1'b0, 1'b1);
        check_flags("idle_lr_ignored", 4'b1000);
        apply_stimulus(1'b1, 1'b0);
        check_flags("start_run", 4'b0100);

        div_clk = 1'b1;
        @(negedge clk);
        div_clk = 1'b0;
        check_display("tick_edge1", 16'h0000);
        @(negedge clk);
        check_display("tick_edge2", 16'h0000);
        @(negedge clk);
        check_display("tick_edge3", 16'h0001);
        repeat (2) tick_once();
        check_display("run_0003", 16'h0003);
        check_flags("run_flags", 4'b0100);

        repeat (2) tick_once();
        apply_stimulus(1'b0, 1'b1);
        check_flags("lap_flags", 4'b0110);
        check_display("lap_enter", 16'h0005);
        repeat (4) tick_once();
        check_display("lap_frozen", 16'h0005);
        apply_stimulus(1'b0, 1'b1);
        check_display("lap_exit_live", 16'h0009);
        check_flags("lap_exit_flags", 4'b0100);

        apply_stimulus(1'b1, 1'b0);
        check_flags("pause_flags", 4'b1000);
        check_display("pause_display", 16'h0009);
        apply_stimulus(1'b0, 1'b1);
        check_display("pause_clear", 16'h0000);
        check_flags("idle_flags", 4'b1000);

        apply_stimulus(1'b1, 1'b0);
        repeat (7) tick_once();
        check_display("run_0007", 16'h0007);
        tick_with_button(1'b1, 1'b0);
        check_display("stop_tick_counted", 16'h0008);
        check_flags("stop_tick_flags", 4'b1000);
        repeat (5) tick_once();
        check_display("pause_ticks_dropped", 16'h0008);
        tick_with_button(1'b1, 1'b0);
        check_display("resume_tick_dropped", 16'h0008);
        check_flags("resume_flags", 4'b0100);
        tick_once();
        check_display("resume_counting", 16'h0009);

        apply_stimulus(1'b1, 1'b1);
        check_flags("both_btn_pause", 4'b1000);
        check_display("both_btn_display", 16'h0009);
        apply_stimulus(1'b0, 1'b1);
        check_display("both_then_clear", 16'h0000);

        apply_stimulus(1'b1, 1'b0);
        div_clk = 1'b1;
        repeat (50) @(negedge clk);
        div_clk = 1'b0;
        repeat (3) @(negedge clk);
        check_display("long_high_one_tick", 16'h0001);

        repeat (3597) tick_once();
        check_display("reach_5958", 16'h5958);
        tick_once();
        check_display("reach_5959", 16'h5959);
        check_flags("no_ovf_5959", 4'b0100);

`ifdef STOPWATCH_SAT_EN
        tick_once();
        check_display("sat_hold", 16'h5959);
        check_flags("sat_ovf_set", 4'b0101);
        tick_once();
        check_display("sat_hold_again", 16'h5959);
        check_flags("sat_ovf_sticky", 4'b0101);
        apply_stimulus(1'b1, 1'b0);
        check_flags("sat_pause_ovf", 4'b1001);
        apply_stimulus(1'b0, 1'b1);
        check_display("sat_clear_display", 16'h0000);
        check_flags("sat_clear_flags", 4'b1000);
        apply_stimulus(1'b1, 1'b0);
`else
        tick_once();
        check_display("wrap_0000", 16'h0000);
        check_flags("wrap_ovf_pulse", 4'b0101);
        @(negedge clk);
        check_flags("wrap_ovf_end", 4'b0100);
`endif

        tick_once();
        check_display("pre_reset_0001", 16'h0001);
        div_clk = 1'b1;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_display("async_reset_display", 16'h0000);
        check_flags("async_reset_flags", 4'b1000);
        div_clk = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check_display("post_reset_idle", 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
